// File: rtl/meter_sched_pkg.sv
// Shared defaults and FSM state encoding for the meter frame scheduler.
package meter_sched_pkg;
  localparam int DEF_WIDTH          = 32;
  localparam int DEF_MIN_INTERVAL   = 1024;
  localparam int DEF_REFRESH_CYCLES = 65536;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_SEND    = 2'd2
  } state_e;
endpackage

// File: rtl/meter_frame_scheduler_if.sv
// Meter update and frame handshakes between producers, scheduler and serializer.
interface meter_frame_scheduler_if
  import meter_sched_pkg::*;
#(
  parameter int width = DEF_WIDTH
) ();
  logic               l_valid;
  logic               l_ready;
  logic [width-1:0]   l_meter;
  logic               r_valid;
  logic               r_ready;
  logic [width-1:0]   r_meter;
  logic               o_valid;
  logic               o_ready;
  logic [2*width-1:0] o_data;
  logic               o_overwrite;

  // Scheduler side
  modport slave (
    input  l_valid, l_meter, r_valid, r_meter, o_ready,
    output l_ready, r_ready, o_valid, o_data, o_overwrite
  );

  // Producer / serializer side
  modport master (
    output l_valid, l_meter, r_valid, r_meter, o_ready,
    input  l_ready, r_ready, o_valid, o_data, o_overwrite
  );
endinterface

// File: rtl/meter_frame_scheduler_rr_arbiter2.sv
// Two-way round-robin grant; bit 0 is the left channel, pointer starts left.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  // Pointer flips after every granted transfer
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~ptr_q;
  end

  // Pointer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

  // Lone requester wins; contention resolved by the pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/meter_frame_scheduler.sv
// Collects left/right meter updates into shadows and launches rate-limited
// frames {right, left}, with a periodic forced re-send when idle.
module meter_frame_scheduler
  import meter_sched_pkg::*;
#(
  parameter int width          = DEF_WIDTH,
  parameter int min_interval   = DEF_MIN_INTERVAL,
  parameter int refresh_cycles = DEF_REFRESH_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  meter_frame_scheduler_if.slave bus
);
  localparam int IW = $clog2(min_interval);
  localparam int RW = $clog2(refresh_cycles);
  localparam logic [IW-1:0] IV_LOAD = IW'(min_interval - 2);
  localparam logic [RW-1:0] RF_LOAD = RW'(refresh_cycles - 1);

  state_e             state_q, state_d;
  logic [width-1:0]   sl_q, sl_d, sr_q, sr_d;
  logic [1:0]         dirty_q, dirty_d;
  logic [IW-1:0]      iv_q, iv_d;
  logic [RW-1:0]      rf_q, rf_d;
  logic               o_valid_q, o_valid_d;
  logic [2*width-1:0] o_data_q, o_data_d;
  logic               ovw_q, ovw_d;
  logic [1:0]         req, gnt;
  logic               handshake;

  // No grants while a frame is on offer or while held in reset
  assign req       = {bus.r_valid, bus.l_valid} & {2{(state_q != ST_SEND) && reset_n}};
  assign handshake = (state_q == ST_SEND) && bus.o_ready;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign bus.l_ready     = gnt[0];
  assign bus.r_ready     = gnt[1];
  assign bus.o_valid     = o_valid_q;
  assign bus.o_data      = o_data_q;
  assign bus.o_overwrite = ovw_q;

  // Shadow capture; a fresh transfer beats the frame-accept dirty clear
  always_comb begin
    sl_d    = sl_q;
    sr_d    = sr_q;
    dirty_d = dirty_q;
    ovw_d   = |(gnt & dirty_q);
    if (handshake) dirty_d = 2'b00;
    if (gnt[0]) begin
      sl_d       = bus.l_meter;
      dirty_d[0] = 1'b1;
    end
    if (gnt[1]) begin
      sr_d       = bus.r_meter;
      dirty_d[1] = 1'b1;
    end
  end

  // Frame FSM: holdoff interval, refresh countdown and frame launch
  always_comb begin
    state_d   = state_q;
    iv_d      = iv_q;
    rf_d      = rf_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rf_q != '0) rf_d = rf_q - 1'b1;
        if ((|dirty_q) || (rf_q == '0)) begin
          state_d   = ST_SEND;
          o_valid_d = 1'b1;
          // Post-update shadows so a same-cycle transfer is not lost
          o_data_d  = {sr_d, sl_d};
        end
      end
      ST_HOLDOFF: begin
        if (rf_q != '0) rf_d = rf_q - 1'b1;
        if (iv_q == '0) state_d = ST_IDLE;
        else            iv_d    = iv_q - 1'b1;
      end
      ST_SEND: begin
        if (bus.o_ready) begin
          state_d   = ST_HOLDOFF;
          o_valid_d = 1'b0;
          iv_d      = IV_LOAD;
          rf_d      = RF_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sl_q      <= '0;
      sr_q      <= '0;
      dirty_q   <= 2'b00;
      iv_q      <= '0;
      rf_q      <= RF_LOAD;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      ovw_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sl_q      <= sl_d;
      sr_q      <= sr_d;
      dirty_q   <= dirty_d;
      iv_q      <= iv_d;
      rf_q      <= rf_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      ovw_q     <= ovw_d;
    end
  end
endmodule

// File: tb/tb_meter_frame_scheduler.sv
// Randomized bench for meter_frame_scheduler against a launch-timing model.
module tb_meter_frame_scheduler;
  localparam int W = 32;
  localparam int M = 16;
  localparam int R = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  meter_frame_scheduler_if #(.width(W)) bus ();

  meter_frame_scheduler #(.width(W), .min_interval(M), .refresh_cycles(R)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: frame may launch at edge e when e >= m_ok and something is dirty,
  // or unconditionally once e >= m_ref; both deadlines are set by frame accept.
  logic           m_send, m_dl, m_dr, m_ptr, m_ovw;
  logic [W-1:0]   m_sl, m_sr;
  logic [2*W-1:0] m_data;
  int             m_edge, m_ok, m_ref;
  logic           e_lr, e_rr, a_lr, a_rr;

  task automatic model_reset();
    m_send = 0; m_dl = 0; m_dr = 0; m_ptr = 0; m_ovw = 0;
    m_sl = '0; m_sr = '0; m_data = '0;
    m_edge = 0; m_ok = 0; m_ref = R;
  endtask

  task automatic model_ready();
    if (m_send) begin e_lr = 0; e_rr = 0; end
    else if (bus.l_valid && bus.r_valid) begin e_lr = !m_ptr; e_rr = m_ptr; end
    else begin e_lr = bus.l_valid; e_rr = bus.r_valid; end
  endtask

  task automatic model_edge();
    logic any_dirty;
    any_dirty = m_dl || m_dr;
    m_edge++;
    m_ovw = (e_lr && m_dl) || (e_rr && m_dr);
    if (e_lr) begin m_sl = bus.l_meter; m_dl = 1; end
    if (e_rr) begin m_sr = bus.r_meter; m_dr = 1; end
    if (e_lr || e_rr) m_ptr = !m_ptr;
    if (m_send) begin
      if (bus.o_ready) begin
        m_send = 0; m_dl = 0; m_dr = 0;
        m_ok = m_edge + M; m_ref = m_edge + R;
      end
    end else if (m_edge >= m_ok && (any_dirty || m_edge >= m_ref)) begin
      m_send = 1;
      m_data = {m_sr, m_sl};
    end
  endtask

  // One clock: drive at negedge, sample readys, step model, return at next negedge
  task automatic cyc(input logic lv, input logic [W-1:0] lm, input logic rv,
                     input logic [W-1:0] rm, input logic ordy);
    bus.l_valid = lv; bus.l_meter = lm; bus.r_valid = rv; bus.r_meter = rm; bus.o_ready = ordy;
    #1;
    model_ready();
    a_lr = bus.l_ready; a_rr = bus.r_ready;
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.l_valid = 0; bus.r_valid = 0; bus.l_meter = '0; bus.r_meter = '0; bus.o_ready = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    logic exp_v;
    reset_n = 0; bus.l_valid = 1; bus.r_valid = 1; bus.o_ready = 0;
    #1;
    n_cmp++;
    if ({bus.l_ready, bus.r_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready got %b%b want 00", bus.l_ready, bus.r_ready);
    end
    do_reset();
    n_cmp++;
    if ({bus.o_valid, bus.o_overwrite, bus.o_data} !== {2'b00, {2*W{1'b0}}}) begin
      n_err++; $display("FAIL reset_out got v%b w%b %h want zeros", bus.o_valid, bus.o_overwrite, bus.o_data);
    end
    // First forced frame exactly R cycles after reset release
    for (int k = 1; k <= R; k++) begin
      cyc(0, '0, 0, '0, 0);
      exp_v = (k >= R);
      n_cmp++;
      if (bus.o_valid !== exp_v || bus.o_data !== '0) begin
        n_err++; $display("FAIL first_refresh k=%0d got v%b %h want v%b 0", k, bus.o_valid, bus.o_data, exp_v);
      end
    end
    cyc(0, '0, 0, '0, 1);
    n_cmp++;
    if (bus.o_valid !== 1'b0) begin
      n_err++; $display("FAIL refresh_accept got v%b want v0", bus.o_valid);
    end
  endtask

  task automatic test_single_update();
    do_reset();
    cyc(1, 32'h0000_00FF, 0, '0, 0);
    n_cmp++;
    if ({a_lr, a_rr} !== 2'b10) begin
      n_err++; $display("FAIL single_ready got %b%b want 10", a_lr, a_rr);
    end
    for (int k = 0; k < 2; k++) if (!bus.o_valid) cyc(0, '0, 0, '0, 0);
    n_cmp++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 64'h0000_0000_0000_00FF) begin
      n_err++; $display("FAIL single_frame got v%b %h want v1 00000000000000ff", bus.o_valid, bus.o_data);
    end
    cyc(0, '0, 0, '0, 1);
    n_cmp++;
    if ({bus.o_valid, bus.o_overwrite, bus.o_data} !== {m_send, m_ovw, m_data}) begin
      n_err++; $display("FAIL single_accept got v%b w%b %h want v%b w%b %h",
        bus.o_valid, bus.o_overwrite, bus.o_data, m_send, m_ovw, m_data);
    end
  endtask

  task automatic test_back_to_back();
    logic g[$];
    do_reset();
    for (int k = 0; k < 64 && g.size() < 4; k++) begin
      cyc(1, $urandom, 1, $urandom, 1);
      n_cmp++;
      if ((a_lr && a_rr) || {a_lr, a_rr} !== {e_lr, e_rr}) begin
        n_err++; $display("FAIL b2b_ready got %b%b want %b%b", a_lr, a_rr, e_lr, e_rr);
      end
      if (a_lr) g.push_back(1'b0);
      else if (a_rr) g.push_back(1'b1);
    end
    n_cmp++;
    if (g.size() != 4) begin
      n_err++; $display("FAIL b2b_count got %0d want 4", g.size());
    end
    for (int i = 0; i < g.size(); i++) begin
      n_cmp++;
      if (g[i] !== ((i % 2) == 1)) begin
        n_err++; $display("FAIL b2b_order idx=%0d got %b want %b", i, g[i], (i % 2) == 1);
      end
    end
  endtask

  task automatic test_holdoff();
    logic pl, pr;
    logic [W-1:0] dl, dr;
    int last, launches, ovws;
    logic prev_v;
    pl = 0; pr = 0; dl = '0; dr = '0; last = 0; launches = 0; ovws = 0; prev_v = 0;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k % 3 == 0 && !pl && !pr) begin
        if ($urandom_range(0, 1) == 1) begin pl = 1; dl = $urandom; end
        else begin pr = 1; dr = $urandom; end
      end
      cyc(pl, dl, pr, dr, 1);
      if (a_lr) pl = 0;
      if (a_rr) pr = 0;
      n_cmp++;
      if ({a_lr, a_rr} !== {e_lr, e_rr}) begin
        n_err++; $display("FAIL hold_ready k=%0d got %b%b want %b%b", k, a_lr, a_rr, e_lr, e_rr);
      end
      n_cmp++;
      if ({bus.o_valid, bus.o_overwrite, bus.o_data} !== {m_send, m_ovw, m_data}) begin
        n_err++; $display("FAIL hold_out k=%0d got v%b w%b %h want v%b w%b %h",
          k, bus.o_valid, bus.o_overwrite, bus.o_data, m_send, m_ovw, m_data);
      end
      if (bus.o_valid && !prev_v) begin
        if (launches > 0) begin
          n_cmp++;
          if (k - last < M) begin
            n_err++; $display("FAIL hold_gap got %0d want >=%0d", k - last, M);
          end
        end
        launches++; last = k;
      end
      prev_v = bus.o_valid;
      if (bus.o_overwrite) ovws++;
    end
    n_cmp++;
    if (launches < 5 || ovws == 0) begin
      n_err++; $display("FAIL hold_activity got launches=%0d ovw=%0d want >=5 and >0", launches, ovws);
    end
  endtask

  task automatic test_stall();
    logic [2*W-1:0] saved;
    logic [W-1:0] rdat;
    do_reset();
    cyc(1, $urandom, 0, '0, 0);
    for (int k = 0; k < 8 && !bus.o_valid; k++) cyc(0, '0, 0, '0, 0);
    n_cmp++;
    if (bus.o_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_launch got v%b want v1", bus.o_valid);
    end
    saved = bus.o_data;
    rdat = $urandom;
    for (int k = 0; k < 50; k++) begin
      cyc(0, '0, 1, rdat, 0);
      n_cmp++;
      if ({a_lr, a_rr} !== 2'b00 || bus.o_valid !== 1'b1 || bus.o_data !== saved) begin
        n_err++; $display("FAIL stall_hold k=%0d got rdy=%b%b v%b %h want rdy=00 v1 %h",
          k, a_lr, a_rr, bus.o_valid, bus.o_data, saved);
      end
    end
    cyc(0, '0, 1, rdat, 1);
    cyc(0, '0, 1, rdat, 0);
    n_cmp++;
    if ({a_lr, a_rr} !== 2'b01 || {a_lr, a_rr} !== {e_lr, e_rr}) begin
      n_err++; $display("FAIL stall_release got %b%b want 01", a_lr, a_rr);
    end
  endtask

  task automatic test_refresh();
    logic pl, pr;
    logic [W-1:0] sl, sr;
    int last, launches;
    logic prev_v;
    do_reset();
    sl = $urandom; sr = $urandom; pl = 1; pr = 1;
    for (int k = 0; k < 40 && (pl || pr); k++) begin
      cyc(pl, sl, pr, sr, 1);
      if (a_lr) pl = 0;
      if (a_rr) pr = 0;
    end
    last = 0; launches = 0; prev_v = bus.o_valid;
    for (int k = 0; k < 400; k++) begin
      cyc(0, '0, 0, '0, 1);
      n_cmp++;
      if ({bus.o_valid, bus.o_overwrite, bus.o_data} !== {m_send, m_ovw, m_data}) begin
        n_err++; $display("FAIL refresh_out k=%0d got v%b w%b %h want v%b w%b %h",
          k, bus.o_valid, bus.o_overwrite, bus.o_data, m_send, m_ovw, m_data);
      end
      if (bus.o_valid && !prev_v) begin
        n_cmp++;
        if (bus.o_data !== {sr, sl}) begin
          n_err++; $display("FAIL refresh_data got %h want %h", bus.o_data, {sr, sl});
        end
        if (launches > 0) begin
          n_cmp++;
          if (k - last < R || k - last > R + 2) begin
            n_err++; $display("FAIL refresh_gap got %0d want about %0d", k - last, R);
          end
        end
        launches++; last = k;
      end
      prev_v = bus.o_valid;
    end
    n_cmp++;
    if (launches < 3) begin
      n_err++; $display("FAIL refresh_count got %0d want >=3", launches);
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    cyc(1, $urandom, 0, '0, 0);
    for (int k = 0; k < 8 && !bus.o_valid; k++) cyc(0, '0, 0, '0, 0);
    n_cmp++;
    if (bus.o_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_launch got v%b want v1", bus.o_valid);
    end
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({bus.o_valid, bus.o_overwrite, bus.o_data} !== {2'b00, {2*W{1'b0}}}) begin
      n_err++; $display("FAIL midrst_out got v%b w%b %h want zeros", bus.o_valid, bus.o_overwrite, bus.o_data);
    end
    @(negedge clk);
    reset_n = 1;
    model_reset();
    cyc(1, $urandom, 1, $urandom, 0);
    n_cmp++;
    if ({a_lr, a_rr} !== 2'b10) begin
      n_err++; $display("FAIL midrst_ptr got %b%b want 10", a_lr, a_rr);
    end
  endtask

  task automatic test_random();
    int last, launches;
    logic prev_v;
    last = 0; launches = 0; prev_v = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0), $urandom,
          ($urandom_range(0, 3) != 0));
      n_cmp++;
      if ({a_lr, a_rr} !== {e_lr, e_rr}) begin
        n_err++; $display("FAIL rand_ready k=%0d got %b%b want %b%b", k, a_lr, a_rr, e_lr, e_rr);
      end
      n_cmp++;
      if ({bus.o_valid, bus.o_overwrite, bus.o_data} !== {m_send, m_ovw, m_data}) begin
        n_err++; $display("FAIL rand_out k=%0d got v%b w%b %h want v%b w%b %h",
          k, bus.o_valid, bus.o_overwrite, bus.o_data, m_send, m_ovw, m_data);
      end
      if (bus.o_valid && !prev_v) begin
        if (launches > 0) begin
          n_cmp++;
          if (k - last < M) begin
            n_err++; $display("FAIL rand_gap got %0d want >=%0d", k - last, M);
          end
        end
        launches++; last = k;
      end
      prev_v = bus.o_valid;
    end
  endtask

  initial begin
    model_reset();
    bus.l_valid = 0; bus.r_valid = 0; bus.l_meter = '0; bus.r_meter = '0; bus.o_ready = 0;
    test_reset();
    test_single_update();
    test_back_to_back();
    test_holdoff();
    test_stall();
    test_refresh();
    test_reset_mid_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
